osnt_ipd_delay_sequencer: RTL and testbench

Per-queue controller that drives the inter-packet delay stage's control inputs (`ipd_en`, `use_reg_val`, `delay_reg_val`) from a CPU-programmed table of delay values. It advances to the next entry each time a packet completes on the delay stage's output stream. One instance sits beside each `inter_packet_delay` instance in the `axis_aclk` domain, between the register block and the delay datapath. It replaces the single static delay register with a programmable, optionally looping delay pattern.

---
 rtl/osnt_ipd_seq_pkg.sv | 21 ++
 rtl/ipd_delay_table.sv | 44 ++++
 rtl/osnt_ipd_delay_sequencer.sv | 175 +++++++++++++++++
 tb/tb_osnt_ipd_delay_sequencer.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/osnt_ipd_seq_pkg.sv
// Shared types and constants for the inter-packet-delay sequencer.
package osnt_ipd_seq_pkg;

    localparam int C_DELAY_WIDTH_DEF = 32;
    localparam int C_TABLE_DEPTH_DEF = 16;
    localparam int C_IDX_WIDTH_DEF   = 4;

    localparam logic [31:0] WRAP_CNT_MAX = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } seq_state_t;

    // Loop counter increment that sticks at all-ones instead of rolling over.
    function automatic logic [31:0] wrap_sat_inc(input logic [31:0] cnt);
        return (cnt == WRAP_CNT_MAX) ? cnt : cnt + 32'd1;
    endfunction

endpackage

// File: rtl/ipd_delay_table.sv
// Delay-value table: one flop register per entry, one write port and one
// combinational read port. A read of the address being written in the same
// cycle returns the incoming data, so a load and a write can coincide.
module ipd_delay_table
    import osnt_ipd_seq_pkg::*;
#(
    parameter int C_DELAY_WIDTH = C_DELAY_WIDTH_DEF,
    parameter int C_TABLE_DEPTH = C_TABLE_DEPTH_DEF,
    parameter int C_IDX_WIDTH   = C_IDX_WIDTH_DEF
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_wr_en,
    input  logic [C_IDX_WIDTH-1:0]   i_wr_addr,
    input  logic [C_DELAY_WIDTH-1:0] i_wr_data,
    input  logic [C_IDX_WIDTH-1:0]   i_rd_addr,
    output logic [C_DELAY_WIDTH-1:0] o_rd_data
);

    logic [C_DELAY_WIDTH-1:0] w_mem [C_TABLE_DEPTH];
    logic                     w_bypass;

    genvar gi;
    generate
        for (gi = 0; gi < C_TABLE_DEPTH; gi = gi + 1) begin : g_entry
            logic [C_DELAY_WIDTH-1:0] r_entry;

            // Entry register: cleared only by the hard reset, written when addressed.
            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    r_entry <= '0;
                end else if (i_wr_en && (i_wr_addr == C_IDX_WIDTH'(gi))) begin
                    r_entry <= i_wr_data;
                end
            end

            assign w_mem[gi] = r_entry;
        end
    endgenerate

    assign w_bypass  = i_wr_en && (i_wr_addr == i_rd_addr);
    assign o_rd_data = w_bypass ? i_wr_data : w_mem[i_rd_addr];

endmodule

// File: rtl/osnt_ipd_delay_sequencer.sv
// Per-queue delay sequencer: steps through a CPU-programmed table of delay
// values, advancing one entry per packet completed on the monitored stream,
// and drives the delay stage's control inputs from registered outputs.
module osnt_ipd_delay_sequencer
    import osnt_ipd_seq_pkg::*;
#(
    parameter int C_DELAY_WIDTH = C_DELAY_WIDTH_DEF,
    parameter int C_TABLE_DEPTH = C_TABLE_DEPTH_DEF,
    parameter int C_IDX_WIDTH   = C_IDX_WIDTH_DEF
) (
    input  logic                     i_axis_aclk,
    input  logic                     i_axis_aresetn,
    input  logic                     i_sw_rst,
    input  logic                     i_seq_en,
    input  logic                     i_seq_loop,
    input  logic [C_IDX_WIDTH-1:0]   i_seq_last_idx,
    input  logic                     i_cfg_wr_en,
    input  logic [C_IDX_WIDTH-1:0]   i_cfg_wr_addr,
    input  logic [C_DELAY_WIDTH-1:0] i_cfg_wr_data,
    input  logic                     i_mon_tvalid,
    input  logic                     i_mon_tready,
    input  logic                     i_mon_tlast,
    output logic                     o_ipd_en,
    output logic                     o_use_reg_val,
    output logic [C_DELAY_WIDTH-1:0] o_delay_reg_val,
    output logic [C_IDX_WIDTH-1:0]   o_seq_idx,
    output logic                     o_seq_done,
    output logic [31:0]              o_wrap_cnt
);

    seq_state_t r_state;
    seq_state_t w_state_next;

    logic                     r_ipd_en;
    logic                     r_use_reg_val;
    logic [C_DELAY_WIDTH-1:0] r_delay;
    logic [C_IDX_WIDTH-1:0]   r_seq_idx;
    logic                     r_seq_done;
    logic [31:0]              r_wrap_cnt;

    logic                     w_ipd_en_next;
    logic                     w_use_reg_val_next;
    logic [C_DELAY_WIDTH-1:0] w_delay_next;
    logic [C_IDX_WIDTH-1:0]   w_idx_next;
    logic                     w_seq_done_next;
    logic [31:0]              w_wrap_next;
    logic                     w_load;

    logic                     w_pkt_done;
    logic                     w_abort;
    logic                     w_at_end;
    logic [C_DELAY_WIDTH-1:0] w_rd_data;

    // Pure monitor of the delay stage's output stream.
    assign w_pkt_done = i_mon_tvalid & i_mon_tready & i_mon_tlast;
    // Soft reset behaves as a sequence abort (plus clearing the loop counter).
    assign w_abort    = i_sw_rst | ~i_seq_en;
    // ">=" so a last index lowered below the current one ends the sequence.
    assign w_at_end   = (r_seq_idx >= i_seq_last_idx);

    // The table is always read at the index that will be current next cycle.
    ipd_delay_table #(
        .C_DELAY_WIDTH (C_DELAY_WIDTH),
        .C_TABLE_DEPTH (C_TABLE_DEPTH),
        .C_IDX_WIDTH   (C_IDX_WIDTH)
    ) u_table (
        .i_clk     (i_axis_aclk),
        .i_rst_n   (i_axis_aresetn),
        .i_wr_en   (i_cfg_wr_en),
        .i_wr_addr (i_cfg_wr_addr),
        .i_wr_data (i_cfg_wr_data),
        .i_rd_addr (w_idx_next),
        .o_rd_data (w_rd_data)
    );

    // State register.
    always_ff @(posedge i_axis_aclk or negedge i_axis_aresetn) begin
        if (!i_axis_aresetn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; an abort overrides every transition.
    always_comb begin
        w_state_next = r_state;
        if (w_abort) begin
            w_state_next = IDLE;
        end else begin
            case (r_state)
                IDLE: w_state_next = RUN;
                RUN: begin
                    if (w_pkt_done && w_at_end && !i_seq_loop) begin
                        w_state_next = DONE;
                    end
                end
                DONE:    w_state_next = DONE;
                default: w_state_next = IDLE;
            endcase
        end
    end

    // Output/next-value logic for index, delay, loop counter and flags.
    always_comb begin
        w_idx_next   = r_seq_idx;
        w_delay_next = r_delay;
        w_wrap_next  = r_wrap_cnt;
        w_load       = 1'b0;

        if (i_sw_rst) begin
            w_wrap_next = '0;
        end

        case (w_state_next)
            IDLE: begin
                w_idx_next   = '0;
                w_delay_next = '0;
            end
            RUN: begin
                if (r_state == IDLE) begin
                    w_idx_next = '0;
                    w_load     = 1'b1;
                end else if (w_pkt_done) begin
                    // Staying in RUN at the end implies looping is enabled.
                    if (!w_at_end) begin
                        w_idx_next = r_seq_idx + C_IDX_WIDTH'(1);
                    end else begin
                        w_idx_next  = '0;
                        w_wrap_next = wrap_sat_inc(r_wrap_cnt);
                    end
                    w_load = 1'b1;
                end
            end
            default: begin
                // DONE holds the last entry's index and value.
            end
        endcase

        if (w_load) begin
            w_delay_next = w_rd_data;
        end

        w_ipd_en_next      = (w_state_next != IDLE);
        w_use_reg_val_next = (w_state_next != IDLE);
        w_seq_done_next    = (w_state_next == DONE);
    end

    // Registered outputs.
    always_ff @(posedge i_axis_aclk or negedge i_axis_aresetn) begin
        if (!i_axis_aresetn) begin
            r_ipd_en      <= 1'b0;
            r_use_reg_val <= 1'b0;
            r_delay       <= '0;
            r_seq_idx     <= '0;
            r_seq_done    <= 1'b0;
            r_wrap_cnt    <= '0;
        end else begin
            r_ipd_en      <= w_ipd_en_next;
            r_use_reg_val <= w_use_reg_val_next;
            r_delay       <= w_delay_next;
            r_seq_idx     <= w_idx_next;
            r_seq_done    <= w_seq_done_next;
            r_wrap_cnt    <= w_wrap_next;
        end
    end

    assign o_ipd_en        = r_ipd_en;
    assign o_use_reg_val   = r_use_reg_val;
    assign o_delay_reg_val = r_delay;
    assign o_seq_idx       = r_seq_idx;
    assign o_seq_done      = r_seq_done;
    assign o_wrap_cnt      = r_wrap_cnt;

endmodule

// File: tb/tb_osnt_ipd_delay_sequencer.sv
// Directed bench for the delay sequencer: per-packet expectations go into a
// scoreboard queue when the packet is driven and are checked after the edge.
module tb_osnt_ipd_delay_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sw_rst;
    logic        seq_en;
    logic        seq_loop;
    logic [3:0]  seq_last_idx;
    logic        cfg_wr_en;
    logic [3:0]  cfg_wr_addr;
    logic [31:0] cfg_wr_data;
    logic        mon_tvalid;
    logic        mon_tready;
    logic        mon_tlast;
    logic        ipd_en;
    logic        use_reg_val;
    logic [31:0] delay_reg_val;
    logic [3:0]  seq_idx;
    logic        seq_done;
    logic [31:0] wrap_cnt;

    typedef struct {
        string       tag;
        logic [3:0]  idx;
        logic [31:0] dly;
        logic        done;
        logic [31:0] wrap;
    } exp_t;

    exp_t sb_q[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    always #5 clk = ~clk;

    osnt_ipd_delay_sequencer dut (
        .i_axis_aclk     (clk),
        .i_axis_aresetn  (rst_n),
        .i_sw_rst        (sw_rst),
        .i_seq_en        (seq_en),
        .i_seq_loop      (seq_loop),
        .i_seq_last_idx  (seq_last_idx),
        .i_cfg_wr_en     (cfg_wr_en),
        .i_cfg_wr_addr   (cfg_wr_addr),
        .i_cfg_wr_data   (cfg_wr_data),
        .i_mon_tvalid    (mon_tvalid),
        .i_mon_tready    (mon_tready),
        .i_mon_tlast     (mon_tlast),
        .o_ipd_en        (ipd_en),
        .o_use_reg_val   (use_reg_val),
        .o_delay_reg_val (delay_reg_val),
        .o_seq_idx       (seq_idx),
        .o_seq_done      (seq_done),
        .o_wrap_cnt      (wrap_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_vec++;
        assert (obs === exp_v) else begin
            n_miss++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic check_idle(input string tag, input logic [31:0] wrap);
        check({tag, ".ipd_en"},   32'(ipd_en), 32'd0);
        check({tag, ".use_reg"},  32'(use_reg_val), 32'd0);
        check({tag, ".delay"},    delay_reg_val, 32'd0);
        check({tag, ".idx"},      32'(seq_idx), 32'd0);
        check({tag, ".done"},     32'(seq_done), 32'd0);
        check({tag, ".wrap"},     wrap_cnt, wrap);
        $display("[%0t] %s: idle ipd_en=%0d delay=%0d idx=%0d wrap=%0d",
                 $time, tag, ipd_en, delay_reg_val, seq_idx, wrap_cnt);
    endtask

    task automatic check_run(input string tag, input logic [3:0] idx, input logic [31:0] dly,
                             input logic done, input logic [31:0] wrap);
        check({tag, ".ipd_en"},  32'(ipd_en), 32'd1);
        check({tag, ".use_reg"}, 32'(use_reg_val), 32'd1);
        check({tag, ".delay"},   delay_reg_val, dly);
        check({tag, ".idx"},     32'(seq_idx), 32'(idx));
        check({tag, ".done"},    32'(seq_done), 32'(done));
        check({tag, ".wrap"},    wrap_cnt, wrap);
        $display("[%0t] %s: run delay=%0d idx=%0d done=%0d wrap=%0d",
                 $time, tag, delay_reg_val, seq_idx, seq_done, wrap_cnt);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input string tag, input logic [3:0] idx, input logic [31:0] dly,
                            input logic done, input logic [31:0] wrap);
        exp_t e;
        e.tag  = tag;
        e.idx  = idx;
        e.dly  = dly;
        e.done = done;
        e.wrap = wrap;
        sb_q.push_back(e);
    endtask

    task automatic pop_check();
        exp_t e;
        if (sb_q.size() == 0) begin
            n_vec++;
            n_miss++;
            $error("FAIL scoreboard: observed empty queue expected an entry");
        end else begin
            e = sb_q.pop_front();
            check_run(e.tag, e.idx, e.dly, e.done, e.wrap);
        end
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        cfg_wr_en   = 1'b1;
        cfg_wr_addr = a;
        cfg_wr_data = d;
        step();
        cfg_wr_en   = 1'b0;
    endtask

    // One completed packet; any write set up by the caller lands in the same cycle.
    task automatic pkt(input string tag, input logic [3:0] idx, input logic [31:0] dly,
                       input logic done, input logic [31:0] wrap);
        push_exp(tag, idx, dly, done, wrap);
        mon_tvalid = 1'b1;
        mon_tready = 1'b1;
        mon_tlast  = 1'b1;
        step();
        mon_tvalid = 1'b0;
        mon_tready = 1'b0;
        mon_tlast  = 1'b0;
        cfg_wr_en  = 1'b0;
        pop_check();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n        = 1'b0;
        sw_rst       = 1'b0;
        seq_en       = 1'b0;
        seq_loop     = 1'b0;
        seq_last_idx = 4'd2;
        cfg_wr_en    = 1'b0;
        cfg_wr_addr  = 4'd0;
        cfg_wr_data  = 32'd0;
        mon_tvalid   = 1'b0;
        mon_tready   = 1'b0;
        mon_tlast    = 1'b0;

        step();
        step();
        check_idle("reset", 32'd0);
        rst_n = 1'b1;
        step();

        wr(4'd0, 32'd100);
        wr(4'd1, 32'd200);
        wr(4'd2, 32'd300);

        // One-shot sequence ending in DONE
        seq_en = 1'b1;
        step();
        check_run("start", 4'd0, 32'd100, 1'b0, 32'd0);
        mon_tvalid = 1'b1;
        mon_tready = 1'b1;
        step();
        mon_tvalid = 1'b0;
        mon_tready = 1'b0;
        check_run("no_tlast", 4'd0, 32'd100, 1'b0, 32'd0);
        pkt("once_p1", 4'd1, 32'd200, 1'b0, 32'd0);
        pkt("once_p2", 4'd2, 32'd300, 1'b0, 32'd0);
        pkt("once_p3", 4'd2, 32'd300, 1'b1, 32'd0);
        pkt("once_p4", 4'd2, 32'd300, 1'b1, 32'd0);

        // Looping sequence
        seq_en = 1'b0;
        step();
        check_idle("abort_done", 32'd0);
        seq_loop = 1'b1;
        seq_en   = 1'b1;
        step();
        check_run("loop_start", 4'd0, 32'd100, 1'b0, 32'd0);
        pkt("loop_p1", 4'd1, 32'd200, 1'b0, 32'd0);
        pkt("loop_p2", 4'd2, 32'd300, 1'b0, 32'd0);
        pkt("loop_p3", 4'd0, 32'd100, 1'b0, 32'd1);
        pkt("loop_p4", 4'd1, 32'd200, 1'b0, 32'd1);
        pkt("loop_p5", 4'd2, 32'd300, 1'b0, 32'd1);
        pkt("loop_p6", 4'd0, 32'd100, 1'b0, 32'd2);
        pkt("loop_p7", 4'd1, 32'd200, 1'b0, 32'd2);
        pkt("loop_p8", 4'd2, 32'd300, 1'b0, 32'd2);

        // Drop enable at idx 2, then re-raise
        seq_en = 1'b0;
        step();
        check_idle("drop_idx2", 32'd2);
        seq_en = 1'b1;
        step();
        check_run("reraise", 4'd0, 32'd100, 1'b0, 32'd2);

        // Back-to-back packet completions
        push_exp("b2b_1", 4'd1, 32'd200, 1'b0, 32'd2);
        push_exp("b2b_2", 4'd2, 32'd300, 1'b0, 32'd2);
        mon_tvalid = 1'b1;
        mon_tready = 1'b1;
        mon_tlast  = 1'b1;
        step();
        pop_check();
        step();
        pop_check();
        mon_tvalid = 1'b0;
        mon_tready = 1'b0;
        mon_tlast  = 1'b0;

        // Write-first bypass, then write to the active index
        pkt("wrap3", 4'd0, 32'd100, 1'b0, 32'd3);
        cfg_wr_en   = 1'b1;
        cfg_wr_addr = 4'd1;
        cfg_wr_data = 32'd555;
        pkt("bypass", 4'd1, 32'd555, 1'b0, 32'd3);
        wr(4'd1, 32'd777);
        check_run("active_write", 4'd1, 32'd555, 1'b0, 32'd3);
        pkt("aw_p1", 4'd2, 32'd300, 1'b0, 32'd3);
        pkt("aw_p2", 4'd0, 32'd100, 1'b0, 32'd4);
        pkt("aw_p3", 4'd1, 32'd777, 1'b0, 32'd4);

        // Last index lowered below the current index
        seq_last_idx = 4'd0;
        pkt("shrink", 4'd0, 32'd100, 1'b0, 32'd5);
        seq_last_idx = 4'd2;

        // Soft reset: clears loop count, keeps table
        sw_rst = 1'b1;
        step();
        sw_rst = 1'b0;
        check_idle("sw_rst", 32'd0);
        step();
        check_run("after_sw_rst", 4'd0, 32'd100, 1'b0, 32'd0);
        pkt("tbl_intact", 4'd1, 32'd777, 1'b0, 32'd0);

        // Hard reset mid-run takes effect without a clock edge
        rst_n = 1'b0;
        #2;
        check_idle("async_rst", 32'd0);
        rst_n = 1'b1;
        step();
        check_run("post_rst", 4'd0, 32'd0, 1'b0, 32'd0);
        pkt("tbl_cleared", 4'd1, 32'd0, 1'b0, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
